// File: rtl/uart_rx_op.sv
// ---------------------------------------------------------------------------
// uart_rx_op
//
// UART receiver for 8-bit frames: start bit, 8 data bits LSB first, optional
// parity bit, one stop bit. Bit timing is derived from a shared 16x
// oversampling tick (clk_en); one bit time is 16 ticks. Every received frame
// is delivered with a single-cycle rx_valid strobe plus error flags that hold
// until the next strobe.
//
// Parameters
//   VERIFY_ON    1 = a parity bit sits between the data bits and the stop bit
//   VERIFY_EVEN  1 = even parity (bit == ^data), 0 = odd parity (bit == ~^data)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   clk_en      16x bit-rate tick, one clk cycle wide
//   uart_rx     asynchronous serial input, idle high
//   dataout     last received byte, held until the next frame completes
//   rx_valid    one-cycle strobe: dataout and error flags were just updated
//   parity_err  parity mismatch on the strobed frame (always 0 if !VERIFY_ON)
//   frame_err   stop bit sampled low on the strobed frame
//   uart_busy   registered "receiver not idle" indication
// ---------------------------------------------------------------------------
module uart_rx_op #(
    parameter logic VERIFY_ON   = 1'b0,
    parameter logic VERIFY_EVEN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       uart_rx,
    output logic [7:0] dataout,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       uart_busy
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_VERIFY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    state_t     r_state;
    logic       r_sync1;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [3:0] r_samp_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_perr;
    logic [7:0] r_dataout;
    logic       r_rx_valid;
    logic       r_parity_err;
    logic       r_frame_err;
    logic       r_busy;

    logic       w_fall;
    logic       w_mid;
    logic       w_expected;

    // A start is only a 1->0 transition; a line held low never retriggers.
    assign w_fall     = r_rx_prev & ~r_rx_s;
    // After the start-bit realignment, counter==15 lands in the middle of a bit.
    assign w_mid      = clk_en && (r_samp_cnt == 4'd15);
    assign w_expected = (^r_shift) ^ ~VERIFY_EVEN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_samp_cnt   <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_perr       <= 1'b0;
            r_dataout    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1    <= uart_rx;
            r_rx_s     <= r_sync1;
            r_rx_prev  <= r_rx_s;
            r_rx_valid <= 1'b0;
            r_busy     <= (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    r_samp_cnt <= 4'd0;
                    r_bit_cnt  <= 3'd0;
                    if (w_fall) begin
                        r_perr  <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (clk_en) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                        if (r_samp_cnt == 4'd7) begin
                            if (r_rx_s) begin
                                // Line already high again mid start bit: glitch.
                                r_state <= S_IDLE;
                            end else begin
                                // Re-phase so the next samples fall mid-bit.
                                r_samp_cnt <= 4'd0;
                                r_state    <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (clk_en) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                    end
                    if (w_mid) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= VERIFY_ON ? S_VERIFY : S_STOP;
                        end
                    end
                end

                S_VERIFY: begin
                    if (clk_en) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                    end
                    if (w_mid) begin
                        r_perr  <= (r_rx_s != w_expected);
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (clk_en) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                    end
                    // Leaving mid stop bit leaves half a bit to catch the
                    // next start edge of a back-to-back frame.
                    if (w_mid) begin
                        r_dataout    <= r_shift;
                        r_frame_err  <= ~r_rx_s;
                        r_parity_err <= VERIFY_ON ? r_perr : 1'b0;
                        r_rx_valid   <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dataout    = r_dataout;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign uart_busy  = r_busy;

endmodule

// File: tb/tb_uart_rx_op.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_op
//
// Directed bench for uart_rx_op. Instance A has no parity bit, instance B
// uses even parity; each has its own serial line. A monitor records every
// rx_valid strobe (data, flags, cycle) so the stimulus can check them later.
// ---------------------------------------------------------------------------
module tb_uart_rx_op;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       clk_en = 1'b1;
    logic       rx_a   = 1'b1;
    logic       rx_b   = 1'b1;

    logic [7:0] dataout_a, dataout_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_err    = 0;

    int en_div = 1;
    int en_cnt = 0;
    int cyc    = 0;
    int start_cyc = 0;

    // strobe capture
    int         cnt_a = 0;
    int         cnt_b = 0;
    int         dbl   = 0;
    int         busy_rise_a = 0;
    logic       prev_valid_a = 1'b0;
    logic       prev_valid_b = 1'b0;
    logic       prev_busy_a  = 1'b0;
    logic [7:0] cap_data_a [0:63];
    logic       cap_ferr_a [0:63];
    logic       cap_perr_a [0:63];
    int         cap_cyc_a  [0:63];
    logic [7:0] cap_data_b [0:63];
    logic       cap_ferr_b [0:63];
    logic       cap_perr_b [0:63];

    uart_rx_op #(.VERIFY_ON(1'b0), .VERIFY_EVEN(1'b0)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .uart_rx    (rx_a),
        .dataout    (dataout_a),
        .rx_valid   (valid_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .uart_busy  (busy_a)
    );

    uart_rx_op #(.VERIFY_ON(1'b1), .VERIFY_EVEN(1'b1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .uart_rx    (rx_b),
        .dataout    (dataout_b),
        .rx_valid   (valid_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .uart_busy  (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 16x tick: one pulse every en_div clocks, changed away from posedge
    always @(negedge clk) begin
        if (en_cnt >= en_div - 1) begin
            en_cnt = 0;
            clk_en = 1'b1;
        end else begin
            en_cnt = en_cnt + 1;
            clk_en = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid_a) begin
            if (prev_valid_a) dbl = dbl + 1;
            if (cnt_a < 64) begin
                cap_data_a[cnt_a] = dataout_a;
                cap_ferr_a[cnt_a] = ferr_a;
                cap_perr_a[cnt_a] = perr_a;
                cap_cyc_a[cnt_a]  = cyc;
            end
            cnt_a = cnt_a + 1;
        end
        if (valid_b) begin
            if (prev_valid_b) dbl = dbl + 1;
            if (cnt_b < 64) begin
                cap_data_b[cnt_b] = dataout_b;
                cap_ferr_b[cnt_b] = ferr_b;
                cap_perr_b[cnt_b] = perr_b;
            end
            cnt_b = cnt_b + 1;
        end
        if (busy_a && !prev_busy_a) busy_rise_a = busy_rise_a + 1;
        prev_valid_a = valid_a;
        prev_valid_b = valid_b;
        prev_busy_a  = busy_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic bit_wait();
        repeat (16 * en_div) @(negedge clk);
    endtask

    // Line is left at the stop-bit value when the task returns.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic par_en,
                              input logic par, input logic stop);
        start_cyc = cyc;
        set_line(sel, 1'b0);
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            bit_wait();
        end
        if (par_en) begin
            set_line(sel, par);
            bit_wait();
        end
        set_line(sel, stop);
        bit_wait();
        $display("frame sel=%0d data=%02h par_en=%0d par=%0d stop=%0d", sel, d, par_en, par, stop);
    endtask

    task automatic wait_cnt(input bit sel, input int target, input string tag);
        int n = 0;
        while (((sel ? cnt_b : cnt_a) < target) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, sel ? cnt_b : cnt_a, target);
    endtask

    initial begin
        int base;
        int lat;
        logic [7:0] part;
        logic [7:0] b2b [0:2];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_dataout", dataout_a, 8'h00);
        check("rst_valid",   valid_a,   1'b0);
        check("rst_perr",    perr_a,    1'b0);
        check("rst_ferr",    ferr_a,    1'b0);
        check("rst_busy",    busy_a,    1'b0);
        check("rst_dataout_b", dataout_b, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // ---------------- A5, latency ----------------
        base = cnt_a;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        bit_wait();
        #1;
        check("a5_count", cnt_a, base + 1);
        check("a5_data",  cap_data_a[base], 8'hA5);
        check("a5_ferr",  cap_ferr_a[base], 1'b0);
        check("a5_perr",  cap_perr_a[base], 1'b0);
        lat = cap_cyc_a[base] - start_cyc;
        $display("a5 latency=%0d clk", lat);
        check("a5_latency_in_153_155", (lat >= 153 && lat <= 155), 1'b1);

        // ---------------- parity (instance B, even) ----------------
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        wait_cnt(1'b1, 2, "par_count");
        check("par0_data", cap_data_b[0], 8'h03);
        check("par0_perr", cap_perr_b[0], 1'b0);
        check("par0_ferr", cap_ferr_b[0], 1'b0);
        check("par1_data", cap_data_b[1], 8'h03);
        check("par1_perr", cap_perr_b[1], 1'b1);
        bit_wait();

        // ---------------- 4-clk glitch ----------------
        base = cnt_a;
        lat  = busy_rise_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        bit_wait();
        bit_wait();
        #1;
        $display("glitch busy_rises=%0d strobes=%0d", busy_rise_a - lat, cnt_a - base);
        check("glitch_no_strobe", cnt_a, base);
        check("glitch_busy_pulse", busy_rise_a - lat, 1);
        check("glitch_busy_idle", busy_a, 1'b0);

        // ---------------- stop low + 40-bit break ----------------
        base = cnt_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (39) bit_wait();
        #1;
        check("brk_count", cnt_a, base + 1);
        check("brk_data",  cap_data_a[base], 8'h55);
        check("brk_ferr",  cap_ferr_a[base], 1'b1);
        rx_a = 1'b1;
        repeat (3) bit_wait();
        #1;
        check("brk_no_more", cnt_a, base + 1);
        check("brk_busy_idle", busy_a, 1'b0);

        // ---------------- back-to-back 00, FF, 81 ----------------
        base   = cnt_a;
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h81;
        for (int i = 0; i < 3; i++) send_frame(1'b0, b2b[i], 1'b0, 1'b0, 1'b1);
        wait_cnt(1'b0, base + 3, "b2b_count");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b%0d_data", i), cap_data_a[base + i], b2b[i]);
            check($sformatf("b2b%0d_ferr", i), cap_ferr_a[base + i], 1'b0);
        end
        bit_wait();

        // ---------------- clk_en every 3rd clock ----------------
        en_div = 3;
        bit_wait();
        base = cnt_a;
        send_frame(1'b0, 8'h6B, 1'b0, 1'b0, 1'b1);
        bit_wait();
        #1;
        check("slow_count", cnt_a, base + 1);
        check("slow_data",  cap_data_a[base], 8'h6B);
        check("slow_ferr",  cap_ferr_a[base], 1'b0);
        en_div = 1;
        bit_wait();

        // ---------------- reset in data bit 4 ----------------
        base = cnt_a;
        part = 8'hC3;
        rx_a = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            rx_a = part[i];
            bit_wait();
        end
        rx_a = part[4];
        repeat (8) @(negedge clk);
        #1;
        check("mid_busy", busy_a, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_dataout", dataout_a, 8'h00);
        check("mid_rst_valid",   valid_a,   1'b0);
        check("mid_rst_busy",    busy_a,    1'b0);
        check("mid_rst_ferr",    ferr_a,    1'b0);
        check("mid_rst_perr",    perr_a,    1'b0);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) bit_wait();
        #1;
        check("mid_no_strobe", cnt_a, base);
        check("mid_idle", busy_a, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        bit_wait();
        #1;
        check("post_rst_count", cnt_a, base + 1);
        check("post_rst_data",  cap_data_a[base], 8'h3C);
        check("post_rst_ferr",  cap_ferr_a[base], 1'b0);

        // ---------------- global ----------------
        check("strobe_single_cycle", dbl, 0);
        check("b_total_strobes", cnt_b, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_op.md
Name: uart_rx_op

Overview:
UART receiver that decodes the 8-bit frame format used by the team's UART transmitter: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Timing comes from the shared 16x oversampling enable `clk_en`; one bit time is 16 `clk_en` ticks.
- Sits between the external `uart_rx` pin and the host-side byte consumer.
- Delivers each received byte with a one-cycle valid strobe and per-frame error flags.

Parameters:
VERIFY_ON, 1'b0, 1 = frame carries a parity bit between data and stop.
VERIFY_EVEN, 1'b0, 1 = expected parity bit equals ^data (even); 0 = expected bit equals ~^data (odd). Ignored when VERIFY_ON=0.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
clk_en  input  1  16x bit-rate tick, one clk cycle wide
uart_rx  input  1  asynchronous serial line, idle high
dataout  output  8  last received byte; held until the next frame completes
rx_valid  output  1  one-cycle strobe: dataout and error flags updated
parity_err  output  1  parity mismatch on the frame just strobed; 0 when VERIFY_ON=0
frame_err  output  1  stop bit sampled low on the frame just strobed
uart_busy  output  1  high while state != IDLE

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is clk.
- Reset values: dataout=8'h00, rx_valid=0, parity_err=0, frame_err=0, uart_busy=0, state=IDLE, bit counter=0, sample counter=0.
- The synchronizer flops also reset to 1; rx_prev also resets to 1.
- Input synchronizer:
  - uart_rx passes through 2 flops to give rx_s.
  - A third flop gives rx_prev.
  - All decode uses rx_s; synchronizer latency is 2 clk.
- States, one-hot: IDLE, START_BIT, DATA_BIT, VERIFY_BIT, STOP_BIT.
- Sample counter, 4-bit:
  - Cleared in IDLE.
  - In all other states it increments on clk_en and wraps 15->0.
- IDLE:
  - A falling edge (rx_prev=1, rx_s=0) moves to START_BIT with the counter at 0.
  - A line held low (break) does not retrigger; a new 1->0 edge is required.
- START_BIT:
  - On clk_en with counter==7 (mid start bit), rx_s is checked.
  - rx_s=1: false start, return to IDLE with no strobe.
  - rx_s=0: clear the counter to 0 and go to DATA_BIT. All later samples then fall mid-bit, at clk_en with counter==15.
- DATA_BIT:
  - At each mid-bit sample, rx_s is shifted into the shift register MSB and the register shifts right, so the first bit received lands in bit 0 after 8 samples. The bit counter increments.
  - After the 8th sample (bit counter==7), go to VERIFY_BIT if VERIFY_ON, else STOP_BIT. The bit counter is 3-bit and returns to 0.
- VERIFY_BIT:
  - At the mid-bit sample, store perr = (rx_s != expected), where expected = (^shift) ^ ~VERIFY_EVEN.
  - Then go to STOP_BIT.
- STOP_BIT: at the mid-bit sample, on the same edge:
  - dataout <= shift.
  - frame_err <= ~rx_s.
  - parity_err <= perr (0 if !VERIFY_ON).
  - rx_valid <= 1.
  - state <= IDLE.
- rx_valid strobe:
  - Exactly one clk cycle; rx_valid returns to 0 on the next clk.
  - A strobe is issued even when an error flag is set. The flags hold until the next strobe.
- Return to IDLE is mid-stop-bit, so the next start edge can be accepted half a bit later. Back-to-back frames with no gap must be received without loss.
- Stop bit low (frame_err): returning to IDLE and then waiting for a fresh falling edge prevents a stuck-low line from generating repeated frames.
- uart_busy: registered, high the cycle after leaving IDLE, low the cycle after entering IDLE.
- Asynchronous reset mid-frame:
  - Aborts immediately and all outputs return to reset values.
  - A partial frame is discarded with no strobe.
  - After reset, reception starts only on a new falling edge.
- clk_en low for extended periods freezes all counters; no timeout.

Test Plan:
- clk_en=1 every cycle, VERIFY_ON=0; send 8'hA5 (16 clk/bit, stop high) -> exactly one rx_valid pulse, dataout=8'hA5, parity_err=0, frame_err=0, pulse 2 clk + 152 ticks after the start edge (±1).
- VERIFY_ON=1, VERIFY_EVEN=1; send 8'h03 with parity 0, then 8'h03 with parity 1 -> first frame parity_err=0, second frame parity_err=1; dataout=8'h03 both times.
- Low glitch of 4 clk on an idle line -> no rx_valid, uart_busy pulses then returns to 0, state returns to IDLE.
- Send 8'h55 with the stop bit forced low, line held low 40 bit times, then high -> one strobe with frame_err=1, dataout=8'h55; no further strobes until a new falling edge.
- Frames 8'h00, 8'hFF, 8'h81 back-to-back with no idle gap -> three strobes in order with correct data and no errors.
- Assert reset mid data bit 4 of a frame -> outputs at reset values, no strobe; next full frame 8'h3C is received correctly.
